hall_sensor_decoder: RTL

HALL_SENSOR_DECODER -- requirements
Module: hall_sensor_decoder

---
 rtl/hall_sensor_decoder.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/hall_sensor_decoder.sv
`default_nettype none
// ============================================================================
// Module   : hall_sensor_decoder
// Purpose  : Synchronizes, debounces and decodes 3-phase hall sensors into
//            sector, direction, step pulses, step period and stall status.
//            Define HALL_POSITION_COUNTER_EN to build the signed step counter.
// Revision : 1.0 - initial release
// ============================================================================
module hall_sensor_decoder #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int PERIOD_WIDTH    = 32,
  parameter int TIMEOUT         = 50000000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    hall_sensor1,
  input  logic                    hall_sensor2,
  input  logic                    hall_sensor3,
  output logic [2:0]              sector,
  output logic                    direction,
  output logic                    step_pulse,
  output logic [PERIOD_WIDTH-1:0] period,
  output logic                    period_valid,
  output logic                    stalled,
  output logic                    hall_error,
  output logic [31:0]             step_count
);

  localparam int                      c_DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [c_DB_W-1:0]       c_DB_MAX  = c_DB_W'(DEBOUNCE_CYCLES);
  localparam logic [PERIOD_WIDTH-1:0] c_TIMEOUT = PERIOD_WIDTH'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [2:0]              r_sync1;
  logic [2:0]              r_sync2;
  logic [2:0]              r_cand;
  logic [2:0]              r_accepted;
  logic [c_DB_W-1:0]       r_db_cnt;
  logic [PERIOD_WIDTH-1:0] r_pcnt;
  logic                    r_has_step;

  logic       w_accept;
  logic       w_code_valid;
  logic [2:0] w_new_sector;
  logic [2:0] w_sec_inc;
  logic [2:0] w_sec_dec;
  logic       w_fwd;
  logic       w_rev;
  logic       w_step;
  logic       w_err;
  logic       w_load;
  logic       w_restart;
  logic       w_meas;
  logic       w_enter_stall;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync1 <= 3'b000;
      r_sync2 <= 3'b000;
    end else begin
      r_sync1 <= {hall_sensor3, hall_sensor2, hall_sensor1};
      r_sync2 <= r_sync1;
    end
  end

  // r_db_cnt counts consecutive cycles r_cand has been seen; any change restarts at 1.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cand     <= 3'b000;
      r_db_cnt   <= '0;
      r_accepted <= 3'b000;
    end else begin
      if (r_sync2 != r_cand) begin
        r_cand   <= r_sync2;
        r_db_cnt <= c_DB_W'(1);
      end else if (r_db_cnt != c_DB_MAX) begin
        r_db_cnt <= r_db_cnt + c_DB_W'(1);
      end
      if (w_accept) begin
        r_accepted <= r_cand;
      end
    end
  end

  assign w_accept = (r_db_cnt == c_DB_MAX) && (r_cand != r_accepted);

  always_comb begin
    w_code_valid = 1'b1;
    w_new_sector = 3'd0;
    case (r_cand)
      3'b001:  w_new_sector = 3'd0;
      3'b011:  w_new_sector = 3'd1;
      3'b010:  w_new_sector = 3'd2;
      3'b110:  w_new_sector = 3'd3;
      3'b100:  w_new_sector = 3'd4;
      3'b101:  w_new_sector = 3'd5;
      default: w_code_valid = 1'b0;
    endcase
  end

  assign w_sec_inc = (sector == 3'd5) ? 3'd0 : sector + 3'd1;
  assign w_sec_dec = (sector == 3'd0) ? 3'd5 : sector - 3'd1;
  assign w_fwd     = (w_new_sector == w_sec_inc);
  assign w_rev     = (w_new_sector == w_sec_dec);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_step      = 1'b0;
    w_err       = 1'b0;
    w_load      = 1'b0;
    w_restart   = 1'b0;
    if (w_accept) begin
      if (!w_code_valid) begin
        w_err = 1'b1;
      end else if (r_state == ST_INIT) begin
        w_load      = 1'b1;
        w_restart   = 1'b1;
        w_state_nxt = ST_RUN;
      end else if (w_new_sector == sector) begin
        // returning from an invalid code to the same sector is not movement
        w_load = 1'b0;
      end else if (w_fwd || w_rev) begin
        w_step      = 1'b1;
        w_load      = 1'b1;
        w_state_nxt = ST_RUN;
      end else begin
        w_err  = 1'b1;
        w_load = 1'b1;
      end
    end
    if ((r_state == ST_RUN) && !w_step && (r_pcnt == c_TIMEOUT)) begin
      w_state_nxt = ST_STALL;
    end
  end

  assign w_meas        = w_step && (r_state == ST_RUN) && r_has_step;
  assign w_enter_stall = (r_state == ST_RUN) && (w_state_nxt == ST_STALL);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pcnt     <= '0;
      r_has_step <= 1'b0;
    end else begin
      if (w_step || w_restart) begin
        r_pcnt <= '0;
      end else if (r_pcnt != c_TIMEOUT) begin
        r_pcnt <= r_pcnt + PERIOD_WIDTH'(1);
      end
      if (w_restart || w_enter_stall) begin
        r_has_step <= 1'b0;
      end else if (w_step) begin
        r_has_step <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sector       <= 3'd0;
      direction    <= 1'b1;
      step_pulse   <= 1'b0;
      period       <= '0;
      period_valid <= 1'b0;
      stalled      <= 1'b0;
      hall_error   <= 1'b0;
    end else begin
      step_pulse   <= w_step;
      hall_error   <= w_err;
      period_valid <= w_meas;
      stalled      <= (w_state_nxt == ST_STALL);
      if (w_load) begin
        sector <= w_new_sector;
      end
      if (w_step) begin
        direction <= w_fwd;
      end
      if (w_meas) begin
        period <= r_pcnt + PERIOD_WIDTH'(1);
      end else if (w_enter_stall) begin
        period <= '0;
      end
    end
  end

`ifdef HALL_POSITION_COUNTER_EN
  logic [31:0] r_step_count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_step_count <= 32'd0;
    end else if (w_step) begin
      r_step_count <= w_fwd ? (r_step_count + 32'd1) : (r_step_count - 32'd1);
    end
  end

  assign step_count = r_step_count;
`else
  assign step_count = 32'd0;
`endif

endmodule
`default_nettype wire
